rx_cpl_credit_arbiter: RTL and testbench
========================================

# rx_cpl_credit_arbiter

Parametrised completion-credit tracker and request arbiter for the PCIe receive path. It sits between N memory-read requestors and the TX request mux. A request is granted only when the completion header (CH) and completion data (CD) credits it needs are available. The granted amounts are deducted, and credits returned by M completion handlers are summed back in every cycle. Improvements over the single-submitter tracker:
- many simultaneous requestors, arbitrated round-robin with a grant handshake;
- simultaneous multi-handler release;
- infinite-credit mode;
- over-return error detection;
- re-initialisation without reset.

## Interface
Parameters:
- P_REQ_NUM, 4, number of requestors (1..16)
- P_CMPL_NUM, 2, number of completion handlers (1..8)
- P_CH_W, 8, CH credit field width
- P_CD_W, 12, CD credit field width
- P_SKIP_UNFIT, 0, 0 = the round-robin head blocks until it fits; 1 = unfit requestors are skipped

Ports:
- i_Clk  in  1  clock
- i_ARstN  in  1  asynchronous, active-low reset
- iv_ReqValid  in  P_REQ_NUM  request pending, one bit per requestor
- iv_ReqCH  in  P_REQ_NUM*P_CH_W  CH credits needed per requestor; slice k = [k*P_CH_W +: P_CH_W]
- iv_ReqCD  in  P_REQ_NUM*P_CD_W  CD credits needed per requestor
- ov_ReqGrant  out  P_REQ_NUM  one-hot, single-cycle grant pulse, registered
- iv_CmplRel  in  P_CMPL_NUM  credit-release strobe per handler
- iv_CmplCH  in  P_CMPL_NUM*P_CH_W  CH credits released
- iv_CmplCD  in  P_CMPL_NUM*P_CD_W  CD credits released
- i_TotalCredCH  in  P_CH_W  advertised CH total; 0 = infinite
- i_TotalCredCD  in  P_CD_W  advertised CD total; 0 = infinite
- i_Reinit  in  1  single-cycle pulse: reload totals
- i_ClrErr  in  1  clears o_OverReturn
- o_AvailCredCH  out  P_CH_W  available CH credits
- o_AvailCredCD  out  P_CD_W  available CD credits
- o_InfiniteCH  out  1  CH total latched as 0
- o_InfiniteCD  out  1  CD total latched as 0
- o_OverReturn  out  1  sticky error flag
- o_Ready  out  1  high in RUN state

## Operation
- **Reset** (i_ArstN low): every output is 0, state is INIT, and the round-robin pointer is 0.
- **State machine:**
  - INIT: latches both totals into avail and into internal total registers, and latches the infinite flags. It always moves to RUN on the next edge.
  - RUN: i_Reinit moves the block to INIT; that cycle's grant is suppressed.
  - In INIT: no grants are issued and releases are discarded.
- **Totals:** the total inputs are sampled only in INIT. Changes while in RUN are ignored.
- **Fit test, requestor k:** (infiniteCH or ReqCH[k] <= availCH) and (infiniteCD or ReqCD[k] <= availCD). A request needing 0/0 always fits.
- **Eligible requestor:** iv_ReqValid[k], and not ov_ReqGrant[k]. The current grant holder is masked because its valid is still high during the grant cycle.
- **Head candidate:** the first eligible index searched from the pointer, wrapping modulo P_REQ_NUM.
  - P_SKIP_UNFIT=0: grant the head only if it fits; otherwise issue no grant.
  - P_SKIP_UNFIT=1: grant the first eligible requestor that fits.
- **On grant to k:** set the pointer to (k+1) mod P_REQ_NUM. The pointer is unchanged when there is no grant.
- **Requestor rules:**
  - Hold valid and the need fields stable until the grant.
  - Drop valid, or present a new request, on the cycle after the grant.
- **Credit update per field:**
  - Computed as next = avail − granted_need + Σ released, using an internal width of W + clog2(M) + 2 bits.
  - If next > total: avail is set to total and o_OverReturn is set.
  - Underflow cannot occur because of the fit test.
  - Grant and release in the same cycle are both applied.
- **Infinite field:** avail stays 0, nothing is deducted, and releases are ignored; there is no over-return check on that field.
- **Error flag:** o_OverReturn is sticky. i_ClrErr clears it; a new over-return in the same cycle wins over the clear.
- **o_Ready** equals (state == RUN).

## Timing
- Grant latency: valid sampled at edge n produces the grant high after edge n (one cycle), provided the request fits.
- Avail reflects a grant's deduction at the same edge that raises the grant.
- A release at edge n is visible in avail after edge n. It can enable a grant at edge n+1 at the earliest.
- Back-to-back grants to different requestors are possible every cycle.
- The same requestor can be granted at most every other cycle.
- First grant possible: edge 2 after reset deassertion (INIT then RUN).
- i_Reinit at edge n: INIT after n, RUN after n+1.
- Asynchronous reset mid-operation clears grants immediately. In-flight credit accounting is lost by design.

## Test plan
- **Init:** reset, totals CH=8, CD=64 → after 2 edges avail=8/64, o_Ready=1, no grants.
- **Round-robin:** 4 requestors valid, each needing 1/4, totals 8/64 → grants 0,1,2,3,0,... one per cycle; avail decrements 1/4 per grant.
- **Blocking vs skip:** avail 2/16; head needs 4/16, next needs 1/4.
  - P_SKIP_UNFIT=0 → no grant until a release of 2 CH, then the head is granted.
  - P_SKIP_UNFIT=1 → the 1/4 requestor is granted immediately.
- **Multi-release with concurrent grant:** avail 3/10; two handlers release 2/8 and 1/4 while 1/2 is granted → avail 5/20 next cycle.
- **Over-return:** total 8, avail 7, release 3 → avail 8, o_OverReturn=1; i_ClrErr → 0.
- **Infinite CD and reinit:** CD total=0 → o_InfiniteCD=1; a request of 1 CH / 4095 CD is granted with CD avail staying 0. Then i_Reinit with CH total changed to 16 → no grant for 2 cycles, then avail CH=16.

Source files
------------

// File: rtl/rx_cpl_credit_arbiter.sv
// Completion-credit tracker and round-robin request arbiter for the PCIe RX path.
// Grants a requestor only when its CH/CD need fits the available credits; handlers return credits.
module rx_cpl_credit_arbiter #(
    parameter int unsigned P_REQ_NUM    = 4,
    parameter int unsigned P_CMPL_NUM   = 2,
    parameter int unsigned P_CH_W       = 8,
    parameter int unsigned P_CD_W       = 12,
    parameter int unsigned P_SKIP_UNFIT = 0
) (
    input  logic                           i_Clk,
    input  logic                           i_ARstN,
    input  logic [P_REQ_NUM-1:0]           iv_ReqValid,
    input  logic [P_REQ_NUM*P_CH_W-1:0]    iv_ReqCH,
    input  logic [P_REQ_NUM*P_CD_W-1:0]    iv_ReqCD,
    output logic [P_REQ_NUM-1:0]           ov_ReqGrant,
    input  logic [P_CMPL_NUM-1:0]          iv_CmplRel,
    input  logic [P_CMPL_NUM*P_CH_W-1:0]   iv_CmplCH,
    input  logic [P_CMPL_NUM*P_CD_W-1:0]   iv_CmplCD,
    input  logic [P_CH_W-1:0]              i_TotalCredCH,
    input  logic [P_CD_W-1:0]              i_TotalCredCD,
    input  logic                           i_Reinit,
    input  logic                           i_ClrErr,
    output logic [P_CH_W-1:0]              o_AvailCredCH,
    output logic [P_CD_W-1:0]              o_AvailCredCD,
    output logic                           o_InfiniteCH,
    output logic                           o_InfiniteCD,
    output logic                           o_OverReturn,
    output logic                           o_Ready
);

    localparam int unsigned PTR_W = (P_REQ_NUM > 1) ? $clog2(P_REQ_NUM) : 1;
    localparam int unsigned CH_XW = P_CH_W + $clog2(P_CMPL_NUM) + 2;
    localparam int unsigned CD_XW = P_CD_W + $clog2(P_CMPL_NUM) + 2;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [PTR_W-1:0]       ptr_q, ptr_d;
    logic [P_REQ_NUM-1:0]   grant_q, grant_d;
    logic [P_CH_W-1:0]      avail_ch_q, avail_ch_d;
    logic [P_CD_W-1:0]      avail_cd_q, avail_cd_d;
    logic [P_CH_W-1:0]      tot_ch_q, tot_ch_d;
    logic [P_CD_W-1:0]      tot_cd_q, tot_cd_d;
    logic                   inf_ch_q, inf_ch_d;
    logic                   inf_cd_q, inf_cd_d;
    logic                   over_q, over_d;

    logic                   arb_en;
    logic [P_REQ_NUM-1:0]   elig;
    logic [P_REQ_NUM-1:0]   fit;
    logic [P_REQ_NUM-1:0]   grant_sel;
    logic [PTR_W-1:0]       ptr_sel;

    logic [CH_XW-1:0]       rel_sum_ch, need_ch, next_ch;
    logic [CD_XW-1:0]       rel_sum_cd, need_cd, next_cd;
    logic                   over_ch, over_cd;

    assign arb_en = (state_q == ST_RUN) && !i_Reinit;

    always_comb begin
        elig = '0;
        fit  = '0;
        for (int unsigned k = 0; k < P_REQ_NUM; k++) begin
            elig[k] = arb_en && iv_ReqValid[k] && !grant_q[k];
            fit[k]  = (inf_ch_q || (iv_ReqCH[k*P_CH_W +: P_CH_W] <= avail_ch_q)) &&
                      (inf_cd_q || (iv_ReqCD[k*P_CD_W +: P_CD_W] <= avail_cd_q));
        end
    end

    // Walk requestors in priority order from the pointer; compare against k
    // rather than indexing so every select stays a constant after unrolling.
    always_comb begin
        logic        hit;
        int unsigned idx;
        hit       = 1'b0;
        idx       = 0;
        grant_sel = '0;
        ptr_sel   = ptr_q;
        for (int unsigned i = 0; i < P_REQ_NUM; i++) begin
            idx = 32'(ptr_q) + i;
            if (idx >= P_REQ_NUM) begin
                idx = idx - P_REQ_NUM;
            end
            for (int unsigned k = 0; k < P_REQ_NUM; k++) begin
                if (!hit && (k == idx) && elig[k]) begin
                    if (P_SKIP_UNFIT == 0) begin
                        hit = 1'b1;
                        if (fit[k]) begin
                            grant_sel[k] = 1'b1;
                            ptr_sel      = PTR_W'((k + 1) % P_REQ_NUM);
                        end
                    end else if (fit[k]) begin
                        hit          = 1'b1;
                        grant_sel[k] = 1'b1;
                        ptr_sel      = PTR_W'((k + 1) % P_REQ_NUM);
                    end
                end
            end
        end
    end

    always_comb begin
        rel_sum_ch = '0;
        rel_sum_cd = '0;
        for (int unsigned m = 0; m < P_CMPL_NUM; m++) begin
            if (iv_CmplRel[m]) begin
                rel_sum_ch = rel_sum_ch + CH_XW'(iv_CmplCH[m*P_CH_W +: P_CH_W]);
                rel_sum_cd = rel_sum_cd + CD_XW'(iv_CmplCD[m*P_CD_W +: P_CD_W]);
            end
        end
        need_ch = '0;
        need_cd = '0;
        for (int unsigned k = 0; k < P_REQ_NUM; k++) begin
            if (grant_sel[k]) begin
                need_ch = CH_XW'(iv_ReqCH[k*P_CH_W +: P_CH_W]);
                need_cd = CD_XW'(iv_ReqCD[k*P_CD_W +: P_CD_W]);
            end
        end
        next_ch = CH_XW'(avail_ch_q) - need_ch + rel_sum_ch;
        next_cd = CD_XW'(avail_cd_q) - need_cd + rel_sum_cd;
        over_ch = next_ch > CH_XW'(tot_ch_q);
        over_cd = next_cd > CD_XW'(tot_cd_q);
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        grant_d    = '0;
        avail_ch_d = avail_ch_q;
        avail_cd_d = avail_cd_q;
        tot_ch_d   = tot_ch_q;
        tot_cd_d   = tot_cd_q;
        inf_ch_d   = inf_ch_q;
        inf_cd_d   = inf_cd_q;
        over_d     = over_q;
        if (i_ClrErr) begin
            over_d = 1'b0;
        end
        case (state_q)
            ST_INIT: begin
                avail_ch_d = i_TotalCredCH;
                avail_cd_d = i_TotalCredCD;
                tot_ch_d   = i_TotalCredCH;
                tot_cd_d   = i_TotalCredCD;
                inf_ch_d   = (i_TotalCredCH == '0);
                inf_cd_d   = (i_TotalCredCD == '0);
                state_d    = ST_RUN;
            end
            ST_RUN: begin
                if (i_Reinit) begin
                    state_d = ST_INIT;
                end
                grant_d = grant_sel;
                if (|grant_sel) begin
                    ptr_d = ptr_sel;
                end
                // Infinite fields never count, so they hold 0 and skip the over-return check.
                if (!inf_ch_q) begin
                    if (over_ch) begin
                        avail_ch_d = tot_ch_q;
                        over_d     = 1'b1;
                    end else begin
                        avail_ch_d = next_ch[P_CH_W-1:0];
                    end
                end
                if (!inf_cd_q) begin
                    if (over_cd) begin
                        avail_cd_d = tot_cd_q;
                        over_d     = 1'b1;
                    end else begin
                        avail_cd_d = next_cd[P_CD_W-1:0];
                    end
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    always_ff @(posedge i_Clk or negedge i_ARstN) begin
        if (!i_ARstN) begin
            state_q    <= ST_INIT;
            ptr_q      <= '0;
            grant_q    <= '0;
            avail_ch_q <= '0;
            avail_cd_q <= '0;
            tot_ch_q   <= '0;
            tot_cd_q   <= '0;
            inf_ch_q   <= 1'b0;
            inf_cd_q   <= 1'b0;
            over_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            grant_q    <= grant_d;
            avail_ch_q <= avail_ch_d;
            avail_cd_q <= avail_cd_d;
            tot_ch_q   <= tot_ch_d;
            tot_cd_q   <= tot_cd_d;
            inf_ch_q   <= inf_ch_d;
            inf_cd_q   <= inf_cd_d;
            over_q     <= over_d;
        end
    end

    assign ov_ReqGrant   = grant_q;
    assign o_AvailCredCH = avail_ch_q;
    assign o_AvailCredCD = avail_cd_q;
    assign o_InfiniteCH  = inf_ch_q;
    assign o_InfiniteCD  = inf_cd_q;
    assign o_OverReturn  = over_q;
    assign o_Ready       = (state_q == ST_RUN);

endmodule

// File: tb/tb_rx_cpl_credit_arbiter.sv
// Directed bench for rx_cpl_credit_arbiter: a blocking-head and a skip-unfit instance
// share stimulus; expected values are hand-computed.
module tb_rx_cpl_credit_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [31:0] req_ch;
    logic [47:0] req_cd;
    logic [1:0]  rel;
    logic [15:0] rel_ch;
    logic [23:0] rel_cd;
    logic [7:0]  tot_ch;
    logic [11:0] tot_cd;
    logic        reinit;
    logic        clr_err;

    logic [3:0]  b_grant, s_grant;
    logic [7:0]  b_ach, s_ach;
    logic [11:0] b_acd, s_acd;
    logic        b_inf_ch, b_inf_cd, b_over, b_ready;
    logic        s_inf_ch, s_inf_cd, s_over, s_ready;

    int unsigned n_checks;
    int unsigned n_errors;

    rx_cpl_credit_arbiter #(
        .P_REQ_NUM(4), .P_CMPL_NUM(2), .P_CH_W(8), .P_CD_W(12), .P_SKIP_UNFIT(0)
    ) u_dut_block (
        .i_Clk(clk), .i_ARstN(rst_n),
        .iv_ReqValid(req_valid), .iv_ReqCH(req_ch), .iv_ReqCD(req_cd),
        .ov_ReqGrant(b_grant),
        .iv_CmplRel(rel), .iv_CmplCH(rel_ch), .iv_CmplCD(rel_cd),
        .i_TotalCredCH(tot_ch), .i_TotalCredCD(tot_cd),
        .i_Reinit(reinit), .i_ClrErr(clr_err),
        .o_AvailCredCH(b_ach), .o_AvailCredCD(b_acd),
        .o_InfiniteCH(b_inf_ch), .o_InfiniteCD(b_inf_cd),
        .o_OverReturn(b_over), .o_Ready(b_ready)
    );

    rx_cpl_credit_arbiter #(
        .P_REQ_NUM(4), .P_CMPL_NUM(2), .P_CH_W(8), .P_CD_W(12), .P_SKIP_UNFIT(1)
    ) u_dut_skip (
        .i_Clk(clk), .i_ARstN(rst_n),
        .iv_ReqValid(req_valid), .iv_ReqCH(req_ch), .iv_ReqCD(req_cd),
        .ov_ReqGrant(s_grant),
        .iv_CmplRel(rel), .iv_CmplCH(rel_ch), .iv_CmplCD(rel_cd),
        .i_TotalCredCH(tot_ch), .i_TotalCredCD(tot_cd),
        .i_Reinit(reinit), .i_ClrErr(clr_err),
        .o_AvailCredCH(s_ach), .o_AvailCredCD(s_acd),
        .o_InfiniteCH(s_inf_ch), .o_InfiniteCD(s_inf_cd),
        .o_OverReturn(s_over), .o_Ready(s_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int k, input logic [7:0] ch, input logic [11:0] cd);
        req_ch[k*8 +: 8]  = ch;
        req_cd[k*12 +: 12] = cd;
    endtask

    task automatic set_rel(input int m, input logic [7:0] ch, input logic [11:0] cd);
        rel[m]             = 1'b1;
        rel_ch[m*8 +: 8]   = ch;
        rel_cd[m*12 +: 12] = cd;
    endtask

    task automatic clr_rel();
        rel    = '0;
        rel_ch = '0;
        rel_cd = '0;
    endtask

    task automatic do_reinit(input logic [7:0] ch, input logic [11:0] cd);
        tot_ch = ch;
        tot_cd = cd;
        reinit = 1'b1;
        tick();
        check("reinit_ready_low", 32'(b_ready), 32'd0);
        reinit = 1'b0;
        tick();
        check("reinit_ready_high", 32'(b_ready), 32'd1);
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        rst_n     = 1'b0;
        req_valid = '0;
        req_ch    = '0;
        req_cd    = '0;
        clr_rel();
        tot_ch    = 8'd8;
        tot_cd    = 12'd64;
        reinit    = 1'b0;
        clr_err   = 1'b0;

        // Reset state
        #12;
        check("rst_grant", 32'(b_grant), 32'd0);
        check("rst_ach", 32'(b_ach), 32'd0);
        check("rst_ready", 32'(b_ready), 32'd0);
        check("rst_over", 32'(b_over), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tick();
        check("init_ach", 32'(b_ach), 32'd8);
        check("init_acd", 32'(b_acd), 32'd64);
        check("init_ready", 32'(b_ready), 32'd1);
        check("init_grant", 32'(b_grant), 32'd0);

        // Round-robin: all four need 1/4
        for (int k = 0; k < 4; k++) set_req(k, 8'd1, 12'd4);
        req_valid = 4'b1111;
        tick();
        check("rr_g0", 32'(b_grant), 32'b0001);
        check("rr_s_g0", 32'(s_grant), 32'b0001);
        check("rr_ach0", 32'(b_ach), 32'd7);
        check("rr_acd0", 32'(b_acd), 32'd60);
        tick();
        check("rr_g1", 32'(b_grant), 32'b0010);
        check("rr_ach1", 32'(b_ach), 32'd6);
        tick();
        check("rr_g2", 32'(b_grant), 32'b0100);
        tick();
        check("rr_g3", 32'(b_grant), 32'b1000);
        check("rr_s_g3", 32'(s_grant), 32'b1000);
        tick();
        check("rr_g4", 32'(b_grant), 32'b0001);
        check("rr_ach4", 32'(b_ach), 32'd3);
        check("rr_acd4", 32'(b_acd), 32'd44);
        req_valid = '0;
        tick();
        check("rr_idle", 32'(b_grant), 32'd0);

        // Blocking head vs skip: reach avail 2/16 with total 4/16
        do_reinit(8'd4, 12'd16);
        check("bs_init_ach", 32'(b_ach), 32'd4);
        set_req(3, 8'd2, 12'd0);
        req_valid = 4'b1000;
        tick();
        check("bs_pre_g", 32'(b_grant), 32'b1000);
        check("bs_pre_ach", 32'(b_ach), 32'd2);
        check("bs_pre_acd", 32'(b_acd), 32'd16);
        set_req(0, 8'd4, 12'd16);
        set_req(1, 8'd1, 12'd4);
        req_valid = 4'b0011;
        tick();
        check("bs_blk_g", 32'(b_grant), 32'd0);
        check("bs_blk_ach", 32'(b_ach), 32'd2);
        check("bs_skp_g", 32'(s_grant), 32'b0010);
        check("bs_skp_ach", 32'(s_ach), 32'd1);
        check("bs_skp_acd", 32'(s_acd), 32'd12);
        req_valid = 4'b0001;
        set_rel(0, 8'd2, 12'd0);
        tick();
        check("bs_rel_g", 32'(b_grant), 32'd0);
        check("bs_rel_ach", 32'(b_ach), 32'd4);
        check("bs_skp_rel_ach", 32'(s_ach), 32'd3);
        clr_rel();
        tick();
        check("bs_head_g", 32'(b_grant), 32'b0001);
        check("bs_head_ach", 32'(b_ach), 32'd0);
        check("bs_head_acd", 32'(b_acd), 32'd0);
        check("bs_skp_nog", 32'(s_grant), 32'd0);
        req_valid = '0;

        // Multi-release with a concurrent grant
        do_reinit(8'd8, 12'd32);
        set_req(2, 8'd5, 12'd22);
        req_valid = 4'b0100;
        tick();
        check("mr_pre_g", 32'(b_grant), 32'b0100);
        check("mr_pre_ach", 32'(b_ach), 32'd3);
        check("mr_pre_acd", 32'(b_acd), 32'd10);
        set_req(3, 8'd1, 12'd2);
        req_valid = 4'b1000;
        set_rel(0, 8'd2, 12'd8);
        set_rel(1, 8'd1, 12'd4);
        tick();
        check("mr_g", 32'(b_grant), 32'b1000);
        check("mr_ach", 32'(b_ach), 32'd5);
        check("mr_acd", 32'(b_acd), 32'd20);
        check("mr_s_ach", 32'(s_ach), 32'd5);
        check("mr_s_acd", 32'(s_acd), 32'd20);
        req_valid = '0;
        clr_rel();

        // Over-return; total input changed in RUN must be ignored
        do_reinit(8'd8, 12'd32);
        tot_ch = 8'd99;
        set_req(0, 8'd1, 12'd0);
        req_valid = 4'b0001;
        tick();
        check("or_pre_ach", 32'(b_ach), 32'd7);
        req_valid = '0;
        set_rel(0, 8'd3, 12'd0);
        tick();
        check("or_ach", 32'(b_ach), 32'd8);
        check("or_flag", 32'(b_over), 32'd1);
        clr_rel();
        clr_err = 1'b1;
        tick();
        check("or_clr", 32'(b_over), 32'd0);
        set_rel(1, 8'd1, 12'd0);
        tick();
        check("or_set_wins", 32'(b_over), 32'd1);
        check("or_ach2", 32'(b_ach), 32'd8);
        clr_rel();
        tick();
        check("or_clr2", 32'(b_over), 32'd0);
        clr_err = 1'b0;

        // Infinite CD
        do_reinit(8'd8, 12'd0);
        check("inf_cd_flag", 32'(b_inf_cd), 32'd1);
        check("inf_ch_flag", 32'(b_inf_ch), 32'd0);
        check("inf_ach", 32'(b_ach), 32'd8);
        check("inf_acd", 32'(b_acd), 32'd0);
        set_req(1, 8'd1, 12'd4095);
        req_valid = 4'b0010;
        set_rel(1, 8'd0, 12'd100);
        tick();
        check("inf_g", 32'(b_grant), 32'b0010);
        check("inf_g_ach", 32'(b_ach), 32'd7);
        check("inf_g_acd", 32'(b_acd), 32'd0);
        check("inf_no_over", 32'(b_over), 32'd0);
        req_valid = '0;
        clr_rel();

        // Reinit with a pending request: two grant-free cycles, then CH total 16
        set_req(2, 8'd1, 12'd1);
        req_valid = 4'b0100;
        tot_ch = 8'd16;
        reinit = 1'b1;
        tick();
        check("ri_g_c1", 32'(b_grant), 32'd0);
        check("ri_ready_c1", 32'(b_ready), 32'd0);
        reinit = 1'b0;
        tick();
        check("ri_g_c2", 32'(b_grant), 32'd0);
        check("ri_ach", 32'(b_ach), 32'd16);
        tick();
        check("ri_g_c3", 32'(b_grant), 32'b0100);
        check("ri_ach3", 32'(b_ach), 32'd15);
        check("ri_acd3", 32'(b_acd), 32'd0);

        // Asynchronous reset mid-operation
        rst_n = 1'b0;
        #1;
        check("arst_grant", 32'(b_grant), 32'd0);
        check("arst_ach", 32'(b_ach), 32'd0);
        check("arst_ready", 32'(b_ready), 32'd0);
        check("arst_inf_cd", 32'(b_inf_cd), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
